uart_rx_oversampled: RTL and testbench

//  Parametrised UART receiver: oversampled start/bit detection with 3-sample majority vote.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_baud_tick.sv | 32 +++
 rtl/uart_rx_oversampled.sv | 218 +++++++++++++++++++++
 tb/tb_uart_rx_oversampled.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared state encoding, parity constants and helpers for the oversampled UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_PARITY  = 3'd3,
        ST_STOP    = 3'd4,
        ST_BRKWAIT = 3'd5
    } uart_state_e;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned bit_rate,
                                             input int unsigned oversample);
        return clk_hz / (bit_rate * oversample);
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick: one-cycle pulse every DIV clocks, restartable by clear_i.
module uart_baud_tick #(
    parameter int unsigned DIV = 10
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    output logic tick_o
);
    localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q - 1'b1;
        if (clear_i || tick_o) begin
            cnt_d = RELOAD;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampled UART receiver with 3-sample majority vote, framing/break detection.
// Optional parity checking is built when UART_RX_PARITY_EN is defined.
module uart_rx_oversampled #(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned BIT_RATE   = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 uart_rxd,
    input  logic                 uart_rx_en,
    output logic                 uart_rx_valid,
    output logic [DATA_BITS-1:0] uart_rx_data,
    output logic                 uart_rx_break,
    output logic                 uart_rx_ferr,
    output logic                 uart_rx_perr,
    output logic                 uart_rx_busy
);
    import uart_pkg::*;

    localparam int unsigned DIV = calc_div(CLK_HZ, BIT_RATE, OVERSAMPLE);
    localparam int unsigned SCW = $clog2(OVERSAMPLE);
    localparam logic [SCW-1:0] SAMP_A    = SCW'(OVERSAMPLE / 2 - 1);
    localparam logic [SCW-1:0] SAMP_B    = SCW'(OVERSAMPLE / 2);
    localparam logic [SCW-1:0] SAMP_C    = SCW'(OVERSAMPLE / 2 + 1);
    localparam logic [SCW-1:0] SAMP_LAST = SCW'(OVERSAMPLE - 1);
    localparam logic [3:0]     DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);

    if (DIV < 2 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 || DATA_BITS < 5 || DATA_BITS > 9 ||
        STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_cfg_check
        $error("uart_rx_oversampled: unsupported parameter set");
    end

    logic rxd_meta_q, rxd_sync_q, rxd_prev_q;
    logic tick, tick_clr, start_edge, decide, bit_val, par_zero;

    uart_state_e          state_q, state_d;
    logic [SCW-1:0]       samp_cnt_q, samp_cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [1:0]           vote_q, vote_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 ferr_acc_q, ferr_acc_d;
    logic                 valid_q, valid_d, brk_q, brk_d, ferr_q, ferr_d;
    logic [DATA_BITS-1:0] data_q, data_d;

    always_ff @(posedge CLK) begin
        if (reset) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= uart_rxd;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
        end
    end

    assign start_edge = rxd_prev_q & ~rxd_sync_q;
    assign tick_clr   = (state_q == ST_IDLE) && uart_rx_en && start_edge;
    assign decide     = tick && (samp_cnt_q == SAMP_C);
    assign bit_val    = majority3(vote_q[0], vote_q[1], rxd_sync_q);

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk_i   (CLK),
        .reset_i (reset),
        .clear_i (tick_clr),
        .tick_o  (tick)
    );

`ifdef UART_RX_PARITY_EN
    localparam logic PAR_SENSE = (PARITY_ODD != 0) ? uart_pkg::PARITY_ODD : PARITY_EVEN;
    logic par_bit_q, par_bit_d, perr_q, perr_d, par_err;
    assign par_zero = ~par_bit_q;
    assign par_err  = par_bit_q ^ (^shift_q) ^ PAR_SENSE;
`else
    assign par_zero = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        samp_cnt_d = samp_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        vote_d     = vote_q;
        shift_d    = shift_q;
        ferr_acc_d = ferr_acc_q;
        valid_d    = 1'b0;
        brk_d      = 1'b0;
        ferr_d     = 1'b0;
        data_d     = data_q;
`ifdef UART_RX_PARITY_EN
        par_bit_d  = par_bit_q;
        perr_d     = 1'b0;
`endif
        if (tick) begin
            samp_cnt_d = (samp_cnt_q == SAMP_LAST) ? '0 : samp_cnt_q + 1'b1;
            if (samp_cnt_q == SAMP_A) vote_d[0] = rxd_sync_q;
            if (samp_cnt_q == SAMP_B) vote_d[1] = rxd_sync_q;
        end
        // States advance at each bit's decision sample, so the next bit is voted under the new state.
        case (state_q)
            ST_IDLE: if (tick_clr) begin
                state_d    = ST_START;
                samp_cnt_d = '0;
            end
            ST_START: if (decide) begin
                state_d   = bit_val ? ST_IDLE : ST_DATA;
                bit_cnt_d = '0;
            end
            ST_DATA: if (decide) begin
                shift_d    = {bit_val, shift_q[DATA_BITS-1:1]};
                bit_cnt_d  = bit_cnt_q + 4'd1;
                ferr_acc_d = 1'b0;
                if (bit_cnt_q == DATA_LAST) begin
                    bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: if (decide) begin
                par_bit_d = bit_val;
                state_d   = ST_STOP;
            end
`endif
            ST_STOP: if (decide) begin
                if (bit_cnt_q == '0 && !bit_val && shift_q == '0 && par_zero) begin
                    brk_d      = 1'b1;
                    state_d    = ST_BRKWAIT;
                    samp_cnt_d = '0;
                end else if (bit_cnt_q == STOP_LAST) begin
                    valid_d = 1'b1;
                    data_d  = shift_q;
                    ferr_d  = ferr_acc_q | ~bit_val;
`ifdef UART_RX_PARITY_EN
                    perr_d  = par_err;
`endif
                    state_d = ST_IDLE;
                end else begin
                    ferr_acc_d = ferr_acc_q | ~bit_val;
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                end
            end
            ST_BRKWAIT: if (tick) begin
                if (!rxd_sync_q) begin
                    samp_cnt_d = '0;
                end else if (samp_cnt_q == SAMP_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_q != ST_IDLE && !uart_rx_en) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            brk_d   = 1'b0;
            ferr_d  = 1'b0;
            data_d  = data_q;
`ifdef UART_RX_PARITY_EN
            perr_d  = 1'b0;
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            samp_cnt_q <= '0;
            bit_cnt_q  <= '0;
            vote_q     <= '0;
            shift_q    <= '0;
            ferr_acc_q <= 1'b0;
            valid_q    <= 1'b0;
            brk_q      <= 1'b0;
            ferr_q     <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            samp_cnt_q <= samp_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            vote_q     <= vote_d;
            shift_q    <= shift_d;
            ferr_acc_q <= ferr_acc_d;
            valid_q    <= valid_d;
            brk_q      <= brk_d;
            ferr_q     <= ferr_d;
            data_q     <= data_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge CLK) begin
        if (reset) begin
            par_bit_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            par_bit_q <= par_bit_d;
            perr_q    <= perr_d;
        end
    end
    assign uart_rx_perr = perr_q;
`else
    assign uart_rx_perr = 1'b0;
`endif

    assign uart_rx_valid = valid_q;
    assign uart_rx_data  = data_q;
    assign uart_rx_break = brk_q;
    assign uart_rx_ferr  = ferr_q;
    assign uart_rx_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Scoreboard bench for uart_rx_oversampled: directed frames, glitch, break, reset and abort cases.
module tb_uart_rx_oversampled;
    localparam int unsigned CLK_HZ     = 1536000;
    localparam int unsigned BIT_RATE   = 9600;
    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned STOP_BITS  = 1;
    localparam int unsigned PARITY_ODD = 0;
    localparam int BIT_CYC = 160;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rxd = 1'b1;
    logic en = 1'b0;
    logic valid, brk, ferr, perr, busy;
    logic [7:0] data;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
        logic       brk;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    uart_rx_oversampled #(
        .CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .OVERSAMPLE(OVERSAMPLE),
        .DATA_BITS(DATA_BITS), .STOP_BITS(STOP_BITS), .PARITY_ODD(PARITY_ODD)
    ) dut (
        .CLK(clk), .reset(reset), .uart_rxd(rxd), .uart_rx_en(en),
        .uart_rx_valid(valid), .uart_rx_data(data), .uart_rx_break(brk),
        .uart_rx_ferr(ferr), .uart_rx_perr(perr), .uart_rx_busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog expired pending=%0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    // Monitor: pops one expectation per valid/break pulse.
    always @(negedge clk) begin
        if (!reset) begin
            if (valid || brk) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output valid=%0b break=%0b data=%h required=none",
                             valid, brk, data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (brk !== e.brk || valid !== !e.brk ||
                        (!e.brk && (data !== e.data || ferr !== e.ferr || perr !== e.perr))) begin
                        errors++;
                        $display("FAIL frame got valid=%0b brk=%0b data=%h ferr=%0b perr=%0b required brk=%0b data=%h ferr=%0b perr=%0b",
                                 valid, brk, data, ferr, perr, e.brk, e.data, e.ferr, e.perr);
                    end
                end
            end else begin
                checks++;
                if (ferr !== 1'b0 || perr !== 1'b0) begin
                    errors++;
                    $display("FAIL err_qualify ferr=%0b perr=%0b required 0 0", ferr, perr);
                end
            end
        end
    end

    task automatic expect_frame(input logic [7:0] d, input logic fe, input logic pe);
        exp_t e;
        e.data = d; e.ferr = fe; e.perr = pe; e.brk = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic expect_break();
        exp_t e;
        e.data = 8'h00; e.ferr = 1'b0; e.perr = 1'b0; e.brk = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%0b required=%0b", name, act, req);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b, input bit chk);
        rxd = b;
        wait_cyc(60);
        if (chk) check1("busy_in_frame", busy, 1'b1);
        wait_cyc(BIT_CYC - 60);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input bit chk);
        drive_bit(1'b0, chk);
        for (int i = 0; i < 8; i++) drive_bit(d[i], chk);
`ifdef UART_RX_PARITY_EN
        drive_bit(par, chk);
`endif
        drive_bit(stop, chk);
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if (valid !== 1'b0 || brk !== 1'b0 || ferr !== 1'b0 || perr !== 1'b0 ||
            busy !== 1'b0 || data !== 8'h00) begin
            errors++;
            $display("FAIL %s got valid=%0b brk=%0b ferr=%0b perr=%0b busy=%0b data=%h required all 0",
                     name, valid, brk, ferr, perr, busy, data);
        end
    endtask

    initial begin
        wait_cyc(5);
        check_outputs_zero("reset_state");
        reset = 1'b0;
        wait_cyc(2);
        check_outputs_zero("after_reset");
        en = 1'b1;
        wait_cyc(BIT_CYC);

        // 1: 0xA5 8N1, busy checked mid-bit
        expect_frame(8'hA5, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
        wait_cyc(BIT_CYC);
        check1("busy_idle", busy, 1'b0);

        // 2: framing error
        expect_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        rxd = 1'b1;
        wait_cyc(2 * BIT_CYC);

`ifdef UART_RX_PARITY_EN
        // 3: even parity, 0x07 has odd weight so parity bit must be 1
        expect_frame(8'h07, 1'b0, 1'b1);
        send_frame(8'h07, 1'b0, 1'b1, 1'b0);
        wait_cyc(BIT_CYC);
        expect_frame(8'h07, 1'b0, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        wait_cyc(BIT_CYC);
`endif

        // 4: break, then recovery
        expect_break();
        rxd = 1'b0;
        wait_cyc(12 * BIT_CYC);
        rxd = 1'b1;
        wait_cyc(2 * BIT_CYC);
        check1("busy_after_break", busy, 1'b0);
        expect_frame(8'h55, 1'b0, 1'b0);
        send_frame(8'h55, 1'b0, 1'b1, 1'b0);
        wait_cyc(BIT_CYC);

        // 5: short glitch is a false start
        rxd = 1'b0;
        wait_cyc(10);
        check1("busy_glitch_start", busy, 1'b1);
        wait_cyc(20);
        rxd = 1'b1;
        wait_cyc(100);
        check1("busy_glitch_end", busy, 1'b0);
        wait_cyc(BIT_CYC);

        // 6: reset during data bit 4 of 0xC3
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b0);
        rxd = 1'b0;
        wait_cyc(60);
        reset = 1'b1;
        wait_cyc(1);
        check_outputs_zero("mid_frame_reset");
        reset = 1'b0;
        rxd = 1'b1;
        wait_cyc(6 * BIT_CYC);
        expect_frame(8'h81, 1'b0, 1'b0);
        send_frame(8'h81, 1'b0, 1'b1, 1'b0);
        wait_cyc(BIT_CYC);

        // 7: enable dropped mid-frame
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b0);
        rxd = 1'b1;
        wait_cyc(60);
        check1("busy_before_abort", busy, 1'b1);
        en = 1'b0;
        wait_cyc(1);
        check1("busy_after_abort", busy, 1'b0);
        wait_cyc(6 * BIT_CYC);
        checks++;
        if (data !== 8'h81) begin
            errors++;
            $display("FAIL abort_data_hold got=%h required=81", data);
        end
        en = 1'b1;
        wait_cyc(BIT_CYC);

        // 8: back-to-back frames
        expect_frame(8'h00, 1'b0, 1'b0);
        expect_frame(8'hFF, 1'b0, 1'b0);
        expect_frame(8'h5A, 1'b0, 1'b0);
        send_frame(8'h00, 1'b0, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b1, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        rxd = 1'b1;

        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        wait_cyc(10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
